// File: rtl/xdma_pkg.sv
// Shared types for the XDMA burst packer: FSM state encoding and
// burst length container with the "zero means maximum" helper.
package xdma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } xdma_packer_state_e;

  localparam int unsigned XDMA_LEN_W = 16;

  typedef logic [XDMA_LEN_W-1:0] xdma_len_t;

  function automatic xdma_len_t xdma_eff_len(
    input xdma_len_t len,
    input xdma_len_t max_len
  );
    return (len == '0) ? max_len : len;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with occupancy count; registered storage,
// combinational head read.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign usage_o = cnt;
  assign data_o  = mem[rd_ptr];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/xdma_burst_packer.sv
// Collects len beats from the upstream stream, then replays them as one burst.
// Optional partial flush on input inactivity: XDMA_BURST_PACKER_TIMEOUT_EN.
module xdma_burst_packer
  import xdma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned TIMEOUT    = 8,
  localparam int unsigned LW = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [LW-1:0]         len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  partial_o,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  input  logic [DATA_WIDTH-1:0] inp_data_i,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  output logic [DATA_WIDTH-1:0] oup_data_o,
  output logic                  oup_last_o
);

  localparam logic [LW-1:0] ONE = LW'(1);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  xdma_packer_state_e state_q, state_d;

  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [LW-1:0]         usage;
  logic [DATA_WIDTH-1:0] head;
  logic                  in_fire;
  logic                  timeout;

  assign in_fire = inp_valid_i && inp_ready_o;

  fifo_v3 #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_BURST)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage),
    .data_i  (inp_data_i),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

`ifdef XDMA_BURST_PACKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          partial_q;

  always_comb begin
    idle_d = idle_q;
    if (state_q != FILL || in_fire) begin
      idle_d = '0;
    end else if (idle_q != TW'(TIMEOUT)) begin
      idle_d = idle_q + TW'(1);
    end
  end

  // With nothing collected the counter just sits saturated in FILL.
  assign timeout = (state_q == FILL) && !in_fire &&
                   (idle_q == TW'(TIMEOUT)) && (beat_cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q    <= '0;
      partial_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      if (state_q == IDLE && start_i) begin
        partial_q <= 1'b0;
      end else if (timeout) begin
        partial_q <= 1'b1;
      end
    end
  end

  assign partial_o = done_o && partial_q;
`else
  assign timeout   = 1'b0;
  assign partial_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    push        = 1'b0;
    pop         = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    inp_ready_o = 1'b0;
    oup_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d      = LW'(xdma_eff_len(xdma_len_t'(len_i),
                                        xdma_len_t'(MAX_BURST)));
          beat_cnt_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        busy_o      = 1'b1;
        inp_ready_o = !full;
        push        = inp_valid_i && !full;
        if (push) begin
          beat_cnt_d = beat_cnt_q + ONE;
          if (beat_cnt_d == len_q) begin
            state_d = SEND;
          end
        end else if (timeout) begin
          len_d   = beat_cnt_q;
          state_d = SEND;
        end
      end
      SEND: begin
        busy_o      = 1'b1;
        oup_valid_o = !empty;
        pop         = oup_valid_o && oup_ready_i;
        if (pop && usage == ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SEND starts with the whole burst buffered, so one entry left is the last.
  assign oup_last_o = oup_valid_o && (usage == ONE);
  assign oup_data_o = oup_valid_o ? head : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_xdma_burst_packer.sv
// Randomized self-checking bench for xdma_burst_packer against a queue model.
module tb_xdma_burst_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  len_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        partial_o;
  logic        inp_valid_i = 1'b0;
  logic        inp_ready_o;
  logic [31:0] inp_data_i = '0;
  logic        oup_valid_o;
  logic        oup_ready_i = 1'b0;
  logic [31:0] oup_data_o;
  logic        oup_last_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int   last_pos;
  int   unstable;
  int   hung;
  int   early_done;
  logic done_after;
  logic busy_after;
  logic partial_after;
  logic busy_idle;

  xdma_burst_packer #(
    .DATA_WIDTH (32),
    .MAX_BURST  (16),
    .TIMEOUT    (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .partial_o   (partial_o),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .inp_data_i  (inp_data_i),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_data_o  (oup_data_o),
    .oup_last_o  (oup_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_burst(input int len);
    start_i = 1'b1;
    len_i   = 5'(len);
    step();
    start_i = 1'b0;
    len_i   = 5'($urandom_range(0, 16));
  endtask

  task automatic feed(input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < in_q.size() && guard < 1000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        inp_valid_i = 1'b0;
        inp_data_i  = $urandom;
      end else begin
        inp_valid_i = 1'b1;
        inp_data_i  = in_q[i];
      end
      #1;
      if (inp_valid_i && inp_ready_o) i++;
      step();
      guard++;
    end
    inp_valid_i = 1'b0;
    if (i < in_q.size()) hung++;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for 5 cycles first
  task automatic collect(input int mode);
    bit          hold = 0;
    bit          fin = 0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    int          guard = 0;
    got_q.delete();
    last_pos   = -1;
    early_done = 0;
    while (!fin && guard < 500) begin
      case (mode)
        0:       oup_ready_i = 1'b1;
        1:       oup_ready_i = 1'($urandom_range(0, 1));
        default: oup_ready_i = (guard >= 5);
      endcase
      #1;
      if (hold && (oup_valid_o !== 1'b1 || oup_data_o !== pd ||
                   oup_last_o !== pl)) unstable++;
      if (done_o) early_done++;
      hold = oup_valid_o && !oup_ready_i;
      pd   = oup_data_o;
      pl   = oup_last_o;
      if (oup_valid_o && oup_ready_i) begin
        got_q.push_back(oup_data_o);
        if (oup_last_o) begin
          last_pos = got_q.size();
          fin = 1;
        end
      end
      step();
      guard++;
    end
    oup_ready_i = 1'b0;
    if (!fin) hung++;
    done_after    = done_o;
    busy_after    = busy_o;
    partial_after = partial_o;
    step();
    busy_idle = busy_o | done_o;
  endtask

  function automatic int mism();
    int m = 0;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      if (got_q[k] !== exp_q[k]) m++;
    return m;
  endfunction

  task automatic test_reset();
    inp_valid_i = 1'b1;
    inp_data_i  = 32'hdead_beef;
    oup_ready_i = 1'b1;
    start_i     = 1'b1;
    #2;
    checks++;
    if ({busy_o, done_o, partial_o, inp_ready_o, oup_valid_o, oup_last_o,
         oup_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b part=%b rdy=%b vld=%b last=%b data=%h, want all 0",
               busy_o, done_o, partial_o, inp_ready_o, oup_valid_o,
               oup_last_o, oup_data_o);
    end
    inp_valid_i = 1'b0;
    oup_ready_i = 1'b0;
    start_i     = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    checks++;
    if ({busy_o, inp_ready_o, oup_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b vld=%b, want 000",
               busy_o, inp_ready_o, oup_valid_o);
    end
  endtask

  task automatic test_len4();
    in_q.delete();
    for (int k = 0; k < 4; k++) in_q.push_back(32'h10 + 32'(k));
    exp_q = in_q;
    hung = 0;
    unstable = 0;
    start_burst(4);
    feed(0);
    checks++;
    if (oup_valid_o !== 1'b1 || oup_data_o !== 32'h10) begin
      errors++;
      $display("FAIL len4_first_valid: got vld=%b data=%h, want 1 00000010",
               oup_valid_o, oup_data_o);
    end
    collect(0);
    checks++;
    if (got_q.size() != 4 || mism() != 0 || hung != 0) begin
      errors++;
      $display("FAIL len4_data: got n=%0d mism=%0d hung=%0d, want 4 0 0",
               got_q.size(), mism(), hung);
    end
    checks++;
    if (last_pos != 4) begin
      errors++;
      $display("FAIL len4_last: got last at %0d, want 4", last_pos);
    end
    checks++;
    if (done_after !== 1'b1 || early_done != 0 || partial_after !== 1'b0) begin
      errors++;
      $display("FAIL len4_done: got done=%b early=%0d part=%b, want 1 0 0",
               done_after, early_done, partial_after);
    end
  endtask

  task automatic test_max();
    in_q.delete();
    for (int k = 0; k < 16; k++) in_q.push_back($urandom);
    exp_q = in_q;
    hung = 0;
    start_burst(0);
    feed(1);
    collect(0);
    checks++;
    if (got_q.size() != 16 || mism() != 0 || hung != 0) begin
      errors++;
      $display("FAIL max_data: got n=%0d mism=%0d hung=%0d, want 16 0 0",
               got_q.size(), mism(), hung);
    end
    checks++;
    if (last_pos != 16 || done_after !== 1'b1) begin
      errors++;
      $display("FAIL max_last: got last=%0d done=%b, want 16 1",
               last_pos, done_after);
    end
    checks++;
    if (busy_after !== 1'b0 || busy_idle !== 1'b0) begin
      errors++;
      $display("FAIL max_busy: got busy_done=%b busy_idle=%b, want 0 0",
               busy_after, busy_idle);
    end
  endtask

  task automatic test_backpressure();
    in_q.delete();
    for (int k = 0; k < 3; k++) in_q.push_back($urandom);
    exp_q = in_q;
    hung = 0;
    unstable = 0;
    start_burst(3);
    feed(0);
    collect(2);
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles, want 0", unstable);
    end
    checks++;
    if (got_q.size() != 3 || mism() != 0 || last_pos != 3 || hung != 0) begin
      errors++;
      $display("FAIL bp_data: got n=%0d mism=%0d last=%0d hung=%0d, want 3 0 3 0",
               got_q.size(), mism(), last_pos, hung);
    end
  endtask

  task automatic test_start_ignored();
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back($urandom);
    hung = 0;
    start_burst(3);
    in_q.delete();
    in_q.push_back(exp_q[0]);
    feed(0);
    start_i = 1'b1;
    len_i   = 5'd7;
    step();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || inp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL start_ign_fill: got busy=%b rdy=%b, want 1 1",
               busy_o, inp_ready_o);
    end
    in_q.delete();
    in_q.push_back(exp_q[1]);
    in_q.push_back(exp_q[2]);
    feed(0);
    collect(1);
    checks++;
    if (got_q.size() != 3 || mism() != 0 || last_pos != 3 || hung != 0) begin
      errors++;
      $display("FAIL start_ign_len: got n=%0d mism=%0d last=%0d hung=%0d, want 3 0 3 0",
               got_q.size(), mism(), last_pos, hung);
    end
  endtask

  task automatic test_mid_reset();
    in_q.delete();
    in_q.push_back(32'haaaa_0001);
    in_q.push_back(32'haaaa_0002);
    hung = 0;
    start_burst(5);
    feed(0);
    inp_valid_i = 1'b1;
    oup_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, partial_o, inp_ready_o, oup_valid_o, oup_last_o,
         oup_data_o} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got busy=%b rdy=%b vld=%b data=%h, want 0",
               busy_o, inp_ready_o, oup_valid_o, oup_data_o);
    end
    step();
    checks++;
    if ({busy_o, done_o, inp_ready_o, oup_valid_o, oup_data_o} !== '0) begin
      errors++;
      $display("FAIL midrst_edge: got busy=%b rdy=%b vld=%b data=%h, want 0",
               busy_o, inp_ready_o, oup_valid_o, oup_data_o);
    end
    inp_valid_i = 1'b0;
    oup_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    in_q.delete();
    in_q.push_back(32'hbbbb_0001);
    in_q.push_back(32'hbbbb_0002);
    exp_q = in_q;
    start_burst(2);
    feed(0);
    collect(0);
    checks++;
    if (got_q.size() != 2 || mism() != 0 || last_pos != 2 || hung != 0) begin
      errors++;
      $display("FAIL midrst_new: got n=%0d mism=%0d last=%0d hung=%0d, want 2 0 2 0",
               got_q.size(), mism(), last_pos, hung);
    end
  endtask

  task automatic test_fill_stall();
    hung = 0;
    start_burst(2);
    repeat (20) step();
    checks++;
    if (busy_o !== 1'b1 || inp_ready_o !== 1'b1 || oup_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: got busy=%b rdy=%b vld=%b, want 1 1 0",
               busy_o, inp_ready_o, oup_valid_o);
    end
    in_q.delete();
    in_q.push_back($urandom);
    in_q.push_back($urandom);
    exp_q = in_q;
    feed(0);
    collect(0);
    checks++;
    if (got_q.size() != 2 || mism() != 0 || partial_after !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: got n=%0d mism=%0d part=%b, want 2 0 0",
               got_q.size(), mism(), partial_after);
    end
  endtask

`ifdef XDMA_BURST_PACKER_TIMEOUT_EN
  task automatic test_timeout();
    in_q.delete();
    for (int k = 0; k < 3; k++) in_q.push_back($urandom);
    exp_q = in_q;
    hung = 0;
    start_burst(8);
    feed(0);
    collect(0);
    checks++;
    if (got_q.size() != 3 || mism() != 0 || last_pos != 3 || hung != 0) begin
      errors++;
      $display("FAIL timeout_data: got n=%0d mism=%0d last=%0d hung=%0d, want 3 0 3 0",
               got_q.size(), mism(), last_pos, hung);
    end
    checks++;
    if (done_after !== 1'b1 || partial_after !== 1'b1) begin
      errors++;
      $display("FAIL timeout_partial: got done=%b part=%b, want 1 1",
               done_after, partial_after);
    end
  endtask
`else
  task automatic test_no_timeout();
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back($urandom);
    hung = 0;
    start_burst(8);
    in_q = exp_q[0:2];
    feed(0);
    repeat (30) step();
    checks++;
    if (busy_o !== 1'b1 || oup_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_wait: got busy=%b vld=%b, want 1 0",
               busy_o, oup_valid_o);
    end
    in_q = exp_q[3:7];
    feed(0);
    collect(0);
    checks++;
    if (got_q.size() != 8 || mism() != 0 || partial_after !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_data: got n=%0d mism=%0d part=%b, want 8 0 0",
               got_q.size(), mism(), partial_after);
    end
  endtask
`endif

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int len = $urandom_range(0, 16);
      int n = (len == 0) ? 16 : len;
      in_q.delete();
      for (int k = 0; k < n; k++) in_q.push_back($urandom);
      exp_q = in_q;
      hung = 0;
      unstable = 0;
      start_burst(len);
      feed(1);
      collect(1);
      checks++;
      if (got_q.size() != n || mism() != 0 || last_pos != n ||
          hung != 0 || unstable != 0) begin
        errors++;
        $display("FAIL rand_burst%0d: got n=%0d mism=%0d last=%0d hung=%0d unst=%0d, want %0d 0 %0d 0 0",
                 b, got_q.size(), mism(), last_pos, hung, unstable, n, n);
      end
      checks++;
      if (done_after !== 1'b1 || early_done != 0 || partial_after !== 1'b0) begin
        errors++;
        $display("FAIL rand_done%0d: got done=%b early=%0d part=%b, want 1 0 0",
                 b, done_after, early_done, partial_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_len4();
    test_max();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_fill_stall();
`ifdef XDMA_BURST_PACKER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xdma_burst_packer.md
XDMA_BURST_PACKER -- requirements
Module: xdma_burst_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the stream beat width in bits.
REQ-002 SHALL have parameter MAX_BURST, default 16, meaning the maximum beats per burst and the internal buffer depth.
REQ-003 SHALL have parameter TIMEOUT, default 8, meaning the number of idle FILL cycles before a partial flush (used only under the macro).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: begin a burst; sampled only in IDLE.
REQ-007 SHALL have port len_i, input, $clog2(MAX_BURST+1) bits: burst length in beats; 0 means MAX_BURST.
REQ-008 SHALL have port busy_o, output, 1 bit: high in FILL and SEND.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse at burst completion.
REQ-010 SHALL have port partial_o, output, 1 bit: qualifies done_o when the burst was cut short by timeout.
REQ-011 SHALL have ports inp_valid_i (input, 1), inp_ready_o (output, 1) and inp_data_i (input, DATA_WIDTH): the upstream stream from the stream arbiter output.
REQ-012 SHALL have ports oup_valid_o (output, 1), oup_ready_i (input, 1), oup_data_o (output, DATA_WIDTH) and oup_last_o (output, 1): the downstream burst stream.

Function
REQ-013 SHALL implement the states IDLE, FILL, SEND and DONE.
REQ-014 IDLE: inp_ready_o=0 and oup_valid_o=0; start_i=1 latches len_i into len_q, clears beat_cnt, and moves to FILL.
REQ-015 FILL: inp_ready_o=1; each inp_valid_i&&inp_ready_o handshake pushes inp_data_i into the buffer and increments beat_cnt.
REQ-016 FILL: the handshake that makes beat_cnt equal to len_q moves to SEND on the next edge; oup_valid_o first rises the cycle after the last accepted beat.
REQ-017 SEND: inp_ready_o=0; oup_valid_o=buffer non-empty; oup_data_o=buffer head; oup_last_o=1 only on the final beat.
REQ-018 SEND: oup_valid_o, oup_data_o and oup_last_o SHALL stay stable while oup_ready_i=0; a pop occurs only on oup_valid_o&&oup_ready_i.
REQ-019 SEND: the handshake of the last beat moves to DONE.
REQ-020 DONE: done_o=1 for exactly one cycle, then the next state is IDLE; start_i in DONE is ignored.
REQ-021 start_i in FILL, SEND or DONE SHALL be ignored, and len_i SHALL be ignored outside IDLE.
REQ-022 Beats SHALL leave in arrival order; the buffer can never overflow because depth equals MAX_BURST.
REQ-023 beat_cnt SHALL be $clog2(MAX_BURST+1) bits and SHALL never wrap.

Reset
REQ-024 Assertion of rst_ni, at any time including mid-burst, SHALL immediately set state to IDLE, clear the buffer, and zero all counters and outputs: busy_o, done_o, partial_o, inp_ready_o, oup_valid_o, oup_last_o, oup_data_o.
REQ-025 Beats buffered at reset SHALL be discarded, not emitted.

Configuration
REQ-026 With macro XDMA_BURST_PACKER_TIMEOUT_EN defined, an idle counter SHALL count FILL cycles without a handshake and clear on each handshake.
REQ-027 Under that macro, when the idle counter reaches TIMEOUT with beat_cnt>=1: len_q:=beat_cnt, move to SEND, and assert partial_o together with done_o.
REQ-028 Under that macro, when the idle counter reaches TIMEOUT with beat_cnt=0: stay in FILL and hold the idle counter saturated.
REQ-029 Without the macro, FILL SHALL wait indefinitely, no idle counter SHALL exist, and partial_o SHALL be tied to 0.

Structure
REQ-030 xdma_pkg SHALL hold the state enum xdma_packer_state_e and the length type xdma_len_t.
REQ-031 The buffer SHALL be one fifo_v3 instance (DEPTH=MAX_BURST, flush_i tied 0); there SHALL be no other sub-module.

Verification
REQ-032 Bench SHALL cover: len_i=4, inputs 0x10..0x13 back-to-back, oup_ready_i=1 -> 4 outputs in order, last on 0x13, done_o one cycle after that handshake.
REQ-033 Bench SHALL cover: len_i=0, 16 inputs -> 16 outputs, last on the 16th beat, busy_o low after done_o.
REQ-034 Bench SHALL cover: len_i=3, oup_ready_i low for 5 cycles during SEND -> data/valid/last stable, no beat lost or duplicated.
REQ-035 Bench SHALL cover: start_i pulsed during FILL with len_i=7 -> ignored, burst completes at the original length.
REQ-036 Bench SHALL cover: rst_ni low after 2 of 5 beats -> all outputs 0 next edge, a new len=2 burst emits only its new data.
REQ-037 Bench SHALL cover, with TIMEOUT_EN: len_i=8, 3 beats then 8 idle cycles -> 3 outputs, last on the 3rd, done_o&&partial_o=1.
